tone_decoder: RTL and testbench

- Receive-side counterpart of the synthesizer: samples the `speaker` square wave and measures its period in clk cycles.
- Matches the period against the eight note periods and reports which button's tone is sounding.
- Used for loop-back self-check and as a bench monitor, placed on the synthesizer's `speaker` net.
- Clock is the same ~5.952 MHz clk as the synthesizer (168 ns period).

---
 rtl/tone_decoder_if.sv | 19 +
 rtl/tone_decoder.sv | 147 ++++++++++++++
 tb/tb_tone_decoder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_decoder_if.sv
// Speaker input and decoded-note outputs of the tone decoder.
// The synthesizer/bench side is master; the decoder is slave.
interface tone_decoder_if;
    logic        speaker;
    logic        note_valid;
    logic [2:0]  note_idx;
    logic [7:0]  btn_decoded;
    logic [15:0] period;
    logic        note_change;

    modport master (
        output speaker,
        input  note_valid, note_idx, btn_decoded, period, note_change
    );
    modport slave (
        input  speaker,
        output note_valid, note_idx, btn_decoded, period, note_change
    );
endinterface

// File: rtl/tone_decoder.sv
// Measures the speaker square-wave period in clk cycles and locks onto the
// matching note after CONFIRM consecutive agreeing periods.
module tone_decoder #(
    parameter logic [127:0] NOTE_P  = {16'd11376, 16'd12052, 16'd13528, 16'd15185,
                                       16'd17044, 16'd18058, 16'd20270, 16'd22751},
    parameter int unsigned  TOL     = 300,
    parameter int unsigned  CONFIRM = 4,
    parameter int unsigned  TIMEOUT = 49152
) (
    input logic           clk,
    input logic           rst,
    tone_decoder_if.slave bus
);
    localparam int unsigned   MW        = $clog2(CONFIRM + 1);
    localparam logic [16:0]   TOL_W     = 17'(TOL);
    localparam logic [16:0]   TIMEOUT_W = 17'(TIMEOUT);
    localparam logic [MW-1:0] CONFIRM_W = MW'(CONFIRM);

    typedef enum logic [1:0] {IDLE, LOCKING, LOCKED} state_t;

    logic [2:0]    sync_q;
    logic [16:0]   cnt_q;
    logic [15:0]   period_q;
    logic          edge_q, mvalid_q;
    logic          hit_q, hit_d;
    logic [2:0]    hidx_q, hidx_d;
    state_t        state_q;
    logic [2:0]    cand_q, cand_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic          valid_q, change_q;
    logic [2:0]    idx_q;
    logic [7:0]    btn_q;
    logic          edge_w, timeout_w;

    // sync_q[1] is the second synchronizer stage, sync_q[2] its delayed copy.
    assign edge_w    = sync_q[1] & ~sync_q[2];
    assign timeout_w = (cnt_q == TIMEOUT_W) && !edge_w;

    always_comb begin
        logic signed [16:0] diff;
        logic [16:0]        mag;
        diff   = '0;
        mag    = '0;
        hit_d  = 1'b0;
        hidx_d = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            diff = $signed({1'b0, period_q}) - $signed({1'b0, NOTE_P[16*i +: 16]});
            mag  = diff[16] ? -diff : diff;
            if (!hit_d && mag <= TOL_W) begin
                hit_d  = 1'b1;
                hidx_d = 3'(i);
            end
        end
    end

    // In LOCKED, cand_q equals idx_q, so the same run-length rule serves both states.
    always_comb begin
        cand_d = hit_q ? hidx_q : cand_q;
        if (!hit_q)
            mcnt_d = '0;
        else if (hidx_q == cand_q)
            mcnt_d = mcnt_q + 1'b1;
        else
            mcnt_d = MW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            edge_q   <= 1'b0;
            mvalid_q <= 1'b0;
            hit_q    <= 1'b0;
            hidx_q   <= '0;
        end else begin
            sync_q   <= {sync_q[1:0], bus.speaker};
            edge_q   <= edge_w;
            mvalid_q <= edge_q;
            hit_q    <= hit_d;
            hidx_q   <= hidx_d;
            if (edge_w) begin
                cnt_q    <= 17'd1;
                period_q <= cnt_q[16] ? 16'hFFFF : cnt_q[15:0];
            end else if (!(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            mcnt_q   <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            btn_q    <= '0;
            change_q <= 1'b0;
        end else begin
            change_q <= 1'b0;
            if (timeout_w) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                idx_q   <= '0;
                btn_q   <= '0;
                mcnt_q  <= '0;
            end else if (mvalid_q) begin
                unique case (state_q)
                    IDLE: begin
                        // The first edge's period is partial; consume its result unused.
                        state_q <= LOCKING;
                        mcnt_q  <= '0;
                    end
                    LOCKING: begin
                        cand_q <= cand_d;
                        mcnt_q <= mcnt_d;
                        if (mcnt_d == CONFIRM_W) begin
                            state_q  <= LOCKED;
                            valid_q  <= 1'b1;
                            idx_q    <= cand_d;
                            btn_q    <= 8'b1 << cand_d;
                            change_q <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!(hit_q && hidx_q == idx_q)) begin
                            state_q <= LOCKING;
                            valid_q <= 1'b0;
                            idx_q   <= '0;
                            btn_q   <= '0;
                            cand_q  <= cand_d;
                            mcnt_q  <= mcnt_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.note_valid  = valid_q;
    assign bus.note_idx    = idx_q;
    assign bus.btn_decoded = btn_q;
    assign bus.period      = period_q;
    assign bus.note_change = change_q;
endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder with note periods scaled down so every scenario fits
// a short run; a period-list reference model checks outputs every cycle.
`timescale 1ns/1ps
module tb_tone_decoder;
    localparam int TOL     = 9;
    localparam int CONFIRM = 4;
    localparam int TIMEOUT = 600;

    logic clk = 1'b0;
    logic rst = 1'b0;
    tone_decoder_if bus();

    tone_decoder #(
        .NOTE_P ({16'd100, 16'd120, 16'd140, 16'd160, 16'd180, 16'd200, 16'd220, 16'd240}),
        .TOL    (TOL),
        .CONFIRM(CONFIRM),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #84 clk = ~clk;

    int notes[8] = '{240, 220, 200, 180, 160, 140, 120, 100};

    int n_pass  = 0;
    int n_total = 0;
    int t       = 0;
    int nchg    = 0;

    // Reference model state: speaker history, run of identical note matches.
    logic [3:0] h;
    bit m_idle, m_valid, m_change, m_pknown, m_haver, m_pend;
    int m_run, m_cur, m_period, m_rlast, m_pend_t, m_pend_p;

    typedef struct {
        int per;
        int n;
        int exp_valid;
        int exp_idx;
        int exp_period;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, t);
    endtask

    function automatic int classify(input int p);
        for (int i = 0; i < 8; i++) begin
            if (((p > notes[i]) ? p - notes[i] : notes[i] - p) <= TOL) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        h = '0;
        m_idle = 1; m_valid = 0; m_change = 0; m_pknown = 1; m_haver = 0; m_pend = 0;
        m_run = 0; m_cur = -1; m_period = 0; m_rlast = 0; m_pend_t = 0; m_pend_p = 0;
    endtask

    // Sample t sees the edge registered when the value driven 3 cycles earlier rose;
    // the lock decision for that period becomes visible 2 samples later.
    task automatic model_update();
        int c;
        bit was;
        m_change = 0;
        if (m_pend && t == m_pend_t) begin
            m_pend = 0;
            if (m_idle) begin
                m_idle = 0;
                m_run  = 0;
            end else begin
                was = m_valid;
                c   = classify(m_pend_p);
                if (c < 0) begin m_run = 0; m_cur = -1; end
                else if (c == m_cur) m_run++;
                else begin m_cur = c; m_run = 1; end
                m_valid  = (m_run >= CONFIRM);
                m_change = m_valid && !was;
            end
        end
        if (h[2] && !h[3]) begin
            if (m_haver) begin
                m_period = (t - m_rlast > 65535) ? 65535 : t - m_rlast;
                m_pknown = 1;
            end else begin
                m_pknown = 0;
            end
            m_haver  = 1;
            m_rlast  = t;
            m_pend   = 1;
            m_pend_t = t + 2;
            m_pend_p = m_period;
        end else if (m_haver && t - m_rlast == TIMEOUT) begin
            m_idle = 1; m_run = 0; m_cur = -1; m_valid = 0;
        end
    endtask

    task automatic step(input logic v);
        int eidx, ebtn;
        bus.speaker = v;
        h = {h[2:0], v};
        @(posedge clk);
        #1;
        t++;
        model_update();
        eidx = m_valid ? m_cur : 0;
        ebtn = m_valid ? (1 << m_cur) : 0;
        if (bus.note_change) nchg++;
        check("cyc_valid", int'(bus.note_valid), int'(m_valid));
        check("cyc_idx", int'(bus.note_idx), eidx);
        check("cyc_btn", int'(bus.btn_decoded), ebtn);
        check("cyc_change", int'(bus.note_change), int'(m_change));
        if (m_pknown) check("cyc_period", int'(bus.period), m_period);
    endtask

    task automatic play(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    task automatic tone(input int p, input int n);
        for (int k = 0; k < n; k++) play(p / 2, p - p / 2);
    endtask

    task automatic quiet(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic do_reset();
        #30;
        rst = 1'b1;
        bus.speaker = 1'b0;
        #1;
        check("rst_async_valid", int'(bus.note_valid), 0);
        check("rst_async_idx", int'(bus.note_idx), 0);
        check("rst_async_btn", int'(bus.btn_decoded), 0);
        check("rst_async_period", int'(bus.period), 0);
        check("rst_async_change", int'(bus.note_change), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int k, base, p, n, hi;
        vecs[0]  = '{240, 6, 1, 0, 240};
        vecs[1]  = '{249, 6, 1, 0, 249};
        vecs[2]  = '{250, 6, 0, 0, 250};
        vecs[3]  = '{149, 6, 1, 5, 149};
        vecs[4]  = '{150, 8, 0, 0, 150};
        vecs[5]  = '{131, 6, 1, 5, 131};
        vecs[6]  = '{130, 6, 0, 0, 130};
        vecs[7]  = '{100, 6, 1, 7, 100};
        vecs[8]  = '{160, 5, 1, 4, 160};
        vecs[9]  = '{160, 4, 0, 0, 160};
        vecs[10] = '{91,  6, 1, 7, 91};
        vecs[11] = '{90,  6, 0, 0, 90};

        bus.speaker = 1'b0;
        model_reset();
        #5 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", int'(bus.note_valid), 0);
        check("reset_idx", int'(bus.note_idx), 0);
        check("reset_btn", int'(bus.btn_decoded), 0);
        check("reset_period", int'(bus.period), 0);
        check("reset_change", int'(bus.note_change), 0);
        @(negedge clk);
        rst = 1'b0;
        quiet(20);

        for (int v = 0; v < 12; v++) begin
            quiet(TIMEOUT + 10);
            tone(vecs[v].per, vecs[v].n);
            quiet(6);
            check($sformatf("vec%0d_valid", v), int'(bus.note_valid), vecs[v].exp_valid);
            check($sformatf("vec%0d_idx", v), int'(bus.note_idx), vecs[v].exp_idx);
            check($sformatf("vec%0d_period", v), int'(bus.period), vecs[v].exp_period);
        end

        // Note change: highest note, then the idx-4 note.
        quiet(TIMEOUT + 10);
        nchg = 0;
        tone(100, 6);
        check("chg_first_idx", int'(bus.note_idx), 7);
        tone(160, 6);
        quiet(6);
        check("chg_valid", int'(bus.note_valid), 1);
        check("chg_idx", int'(bus.note_idx), 4);
        check("chg_btn", int'(bus.btn_decoded), 8'h10);
        check("chg_pulses", nchg, 2);

        // Silence after lock on idx 2.
        quiet(TIMEOUT + 10);
        tone(200, 6);
        check("sil_locked_idx", int'(bus.note_idx), 2);
        k = 0;
        while (bus.note_valid && k < TIMEOUT + 50) begin
            step(1'b0);
            k++;
        end
        check("sil_latency", t - m_rlast, TIMEOUT);
        check("sil_period_hold", int'(bus.period), 200);

        // Edge landing exactly on the timeout cycle, then one cycle later.
        quiet(TIMEOUT + 10);
        tone(100, 6);
        play(50, TIMEOUT - 50);
        play(50, 50);
        quiet(4);
        check("edge_wins_period", int'(bus.period), TIMEOUT);
        quiet(TIMEOUT + 10);
        tone(100, 6);
        play(50, TIMEOUT - 49);
        play(50, 50);
        quiet(4);
        check("late_edge_period", int'(bus.period), TIMEOUT + 1);

        // Glitch while locked on idx 3 splits one period into 130 + 50.
        quiet(TIMEOUT + 10);
        nchg = 0;
        tone(180, 6);
        check("glitch_pre_idx", int'(bus.note_idx), 3);
        play(90, 40);
        play(1, 49);
        tone(180, 5);
        quiet(6);
        check("glitch_valid", int'(bus.note_valid), 1);
        check("glitch_idx", int'(bus.note_idx), 3);
        check("glitch_pulses", nchg, 2);

        // Jitter around idx 5.
        quiet(TIMEOUT + 10);
        for (int j = 0; j < 4; j++) begin
            play(66, 67);
            play(73, 73);
        end
        quiet(6);
        check("jitter_valid", int'(bus.note_valid), 1);
        check("jitter_idx", int'(bus.note_idx), 5);

        // Asynchronous reset while locked on idx 3.
        quiet(TIMEOUT + 10);
        tone(180, 6);
        quiet(3);
        check("pre_rst_idx", int'(bus.note_idx), 3);
        do_reset();
        quiet(50);
        check("post_rst_valid", int'(bus.note_valid), 0);

        // Randomized bursts, duty cycles and gaps.
        for (int r = 0; r < 20; r++) begin
            base = notes[$urandom_range(0, 7)];
            p    = base + int'($urandom_range(0, 24)) - 12;
            n    = int'($urandom_range(2, 7));
            for (int j = 0; j < n; j++) begin
                hi = int'($urandom_range(1, p - 1));
                play(hi, p - hi);
            end
            if ($urandom_range(0, 3) == 0) quiet(int'($urandom_range(1, TIMEOUT + 20)));
        end
        quiet(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
